vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
- REQ-001 SHALL have parameter H_VIS, default 640, visible pixels per line.
- REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in clocks.
- REQ-003 SHALL have parameter H_SYNC, default 96, horizontal sync width in clocks.
- REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in clocks.
- REQ-005 SHALL have parameter V_VIS, default 480, visible lines per frame.
- REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
- REQ-007 SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
- REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
- REQ-009 SHALL have port iVGA_CLK, input, 1, pixel clock (25 MHz nominal); the only clock.
- REQ-010 SHALL have port iRST_N, input, 1, asynchronous active-low reset.
- REQ-011 SHALL have port iRed/iGreen/iBlue, input, 10 each, pixel colour returned by the pattern generator.
- REQ-012 SHALL have port oVGA_X/oVGA_Y, output, 10 each, coordinate requested from the pattern generator.
- REQ-013 SHALL have port oRequest, output, 1, high when oVGA_X/oVGA_Y address a visible pixel.
- REQ-014 SHALL have port oVGA_R/oVGA_G/oVGA_B, output, 10 each, colour to DAC.
- REQ-015 SHALL have ports oVGA_HS/oVGA_VS, output, 1 each, active-low syncs.
- REQ-016 SHALL have port oVGA_BLANK_N, output, 1, low outside the visible area.
- REQ-017 SHALL have port oVGA_SYNC_N, output, 1, tied low.
- REQ-018 SHALL have port oFrame_Tick, output, 1, one-clock pulse per frame, used as the game action clock.

Function
- REQ-019 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and v_cnt 0..V_TOTAL-1 (V_TOTAL = 525); h_cnt increments every clock.
- REQ-020 SHALL, when h_cnt = H_TOTAL-1, wrap h_cnt to 0 and increment v_cnt; when additionally v_cnt = V_TOTAL-1, wrap v_cnt to 0.
- REQ-021 SHALL define visible as h_cnt < H_VIS and v_cnt < V_VIS; counter value 0 is the first visible pixel.
- REQ-022 SHALL register oVGA_X = h_cnt, oVGA_Y = v_cnt and oRequest = visible; oVGA_X/oVGA_Y SHALL read 0 when not visible.
- REQ-023 SHALL treat the pattern generator as one registered stage: colour for the coordinate presented in cycle N is valid on iRed/iGreen/iBlue in cycle N+1.
- REQ-024 SHALL register the input colour into oVGA_R/G/B so the colour for coordinate of cycle N appears in cycle N+2.
- REQ-025 SHALL delay HS, VS and BLANK_N by a 2-stage pipeline so they appear in cycle N+2, aligned with their pixel's colour.
- REQ-026 SHALL assert HS (low) for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [656,751], before delay.
- REQ-027 SHALL assert VS (low) for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [490,491], all h_cnt, before delay.
- REQ-028 SHALL force oVGA_R/G/B to 0 whenever the aligned BLANK_N is low, regardless of inputs.
- REQ-029 SHALL pulse oFrame_Tick for exactly one clock when h_cnt = 0 and v_cnt = V_VIS, at the start of vertical blank.
- REQ-030 SHALL compute all comparisons in 10-bit unsigned with no overflow for default parameters.

Reset
- REQ-031 SHALL, while iRST_N is low, hold h_cnt = v_cnt = 0, oVGA_X = oVGA_Y = 0, oRequest = 0, oVGA_R/G/B = 0, oVGA_HS = oVGA_VS = 1, oVGA_BLANK_N = 0 and oFrame_Tick = 0, and clear the delay pipeline.
- REQ-032 SHALL, on the first rising edge after iRST_N releases, present oVGA_X = 0, oVGA_Y = 0 and oRequest = 1.
- REQ-033 SHALL, on reset asserted mid-frame, abandon the frame immediately and restart at (0,0) with no partial sync pulse.

Structure
- REQ-034 SHALL place the default timing constants and the derived H_TOTAL/V_TOTAL in shared package vga_timing_pkg.
- REQ-035 SHALL use one sub-module, vga_delay_line, as a parameterised-width, parameterised-depth register pipeline for HS/VS/BLANK_N.

Verification
- REQ-036 SHALL check reset release: first edge gives X=0, Y=0, Request=1; HS=VS=1, BLANK_N=0 until cycle 2.
- REQ-037 SHALL check HS: period 800 clocks and low for 96, with the falling edge 658 clocks after the X=0 cycle.
- REQ-038 SHALL check VS: period 420000 clocks and low for 1600; oFrame_Tick period 420000 with exactly one pulse per frame.
- REQ-039 SHALL check alignment using a 1-cycle model loopback iRed = X: oVGA_R equals 0,1,2,...,639 on consecutive BLANK_N-high cycles, and equals 0 when blank.
- REQ-040 SHALL check blank forcing: hold iRed/iGreen/iBlue = 1023 -> oVGA_R/G/B = 0 whenever oVGA_BLANK_N = 0.
- REQ-041 SHALL check mid-frame reset at v_cnt = 300: outputs go to reset values asynchronously, and after release the next frame starts at (0,0).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA timing constants and shared types
package vga_timing_pkg;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOTAL = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int CW = 10;
    typedef logic [CW-1:0] coord_t;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic blank_n;
    } sync_t;

    // Idle (reset) state of the sync bundle: syncs deasserted, blanked.
    localparam sync_t SYNC_IDLE = sync_t'(3'b110);

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - parameterised-width, parameterised-depth register pipeline
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= RST_VAL;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA raster counters, pixel request and DAC-aligned sync/colour outputs
module vga_timing_ctrl
    import vga_timing_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_N,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic [9:0] oVGA_X,
    output logic [9:0] oVGA_Y,
    output logic       oRequest,
    output logic [9:0] oVGA_R,
    output logic [9:0] oVGA_G,
    output logic [9:0] oVGA_B,
    output logic       oVGA_HS,
    output logic       oVGA_VS,
    output logic       oVGA_BLANK_N,
    output logic       oVGA_SYNC_N,
    output logic       oFrame_Tick
);

    localparam coord_t H_VIS_C  = coord_t'(H_VIS);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS);
    localparam coord_t H_LAST   = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_LAST   = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t HS_START = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    coord_t h_cnt_q, h_cnt_d;
    coord_t v_cnt_q, v_cnt_d;
    coord_t x_q, y_q;
    logic   req_q, tick_q;
    logic   visible;
    sync_t  sync_raw, sync1_q, sync_out;
    logic [9:0] r_q, g_q, b_q;

    always_comb begin
        h_cnt_d = h_cnt_q + coord_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + coord_t'(1);
        end
    end

    assign visible          = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    assign sync_raw.hs_n    = !in_window(h_cnt_q, HS_START, HS_END);
    assign sync_raw.vs_n    = !in_window(v_cnt_q, VS_START, VS_END);
    assign sync_raw.blank_n = visible;

    // Stage 1: coordinate request, with the raw syncs captured alongside it.
    always_ff @(posedge iVGA_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            tick_q  <= 1'b0;
            sync1_q <= SYNC_IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            x_q     <= visible ? h_cnt_q : '0;
            y_q     <= visible ? v_cnt_q : '0;
            req_q   <= visible;
            tick_q  <= (h_cnt_q == '0) && (v_cnt_q == V_VIS_C);
            sync1_q <= sync_raw;
            r_q     <= iRed;
            g_q     <= iGreen;
            b_q     <= iBlue;
        end
    end

    // Two more stages line the syncs up with the colour returned by the pattern generator.
    vga_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (2),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk_i  (iVGA_CLK),
        .rst_ni (iRST_N),
        .d_i    (sync1_q),
        .q_o    (sync_out)
    );

    assign oVGA_X       = x_q;
    assign oVGA_Y       = y_q;
    assign oRequest     = req_q;
    assign oFrame_Tick  = tick_q;
    assign oVGA_HS      = sync_out.hs_n;
    assign oVGA_VS      = sync_out.vs_n;
    assign oVGA_BLANK_N = sync_out.blank_n;
    assign oVGA_SYNC_N  = 1'b0;
    assign oVGA_R       = sync_out.blank_n ? r_q : '0;
    assign oVGA_G       = sync_out.blank_n ? g_q : '0;
    assign oVGA_B       = sync_out.blank_n ? b_q : '0;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl with a shortened vertical frame
module tb_vga_timing_ctrl;

    localparam int H_TOT   = 800;
    localparam int H_VIS   = 640;
    localparam int HS0     = 656;
    localparam int HS1     = 751;
    localparam int V_VIS   = 8;
    localparam int V_FP    = 2;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 3;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int VS0     = V_VIS + V_FP;
    localparam int VS1     = V_VIS + V_FP + V_SYNC - 1;
    localparam int FRAME   = H_TOT * V_TOT;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
        logic       hs;
        logic       vs;
        logic       blank;
    } exp_t;

    localparam exp_t EXP_IDLE = '{r: 10'd0, g: 10'd0, b: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b0};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] i_red = '0, i_green = 10'd1023, i_blue = 10'd1023;
    logic [9:0] o_x, o_y, o_r, o_g, o_b;
    logic       o_req, o_hs, o_vs, o_blank_n, o_sync_n, o_tick;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];
    int   mh, mv, cyc;
    logic [9:0] red_pipe;
    logic prev_hs, prev_vs;
    int   hs_fall, vs_fall, tick_last;

    always #5 clk = ~clk;

    vga_timing_ctrl #(
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) dut (
        .iVGA_CLK     (clk),
        .iRST_N       (rst_n),
        .iRed         (i_red),
        .iGreen       (i_green),
        .iBlue        (i_blue),
        .oVGA_X       (o_x),
        .oVGA_Y       (o_y),
        .oRequest     (o_req),
        .oVGA_R       (o_r),
        .oVGA_G       (o_g),
        .oVGA_B       (o_b),
        .oVGA_HS      (o_hs),
        .oVGA_VS      (o_vs),
        .oVGA_BLANK_N (o_blank_n),
        .oVGA_SYNC_N  (o_sync_n),
        .oFrame_Tick  (o_tick)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_x"},     int'(o_x), 0);
        check_eq({pfx, "_y"},     int'(o_y), 0);
        check_eq({pfx, "_req"},   int'(o_req), 0);
        check_eq({pfx, "_r"},     int'(o_r), 0);
        check_eq({pfx, "_g"},     int'(o_g), 0);
        check_eq({pfx, "_b"},     int'(o_b), 0);
        check_eq({pfx, "_hs"},    int'(o_hs), 1);
        check_eq({pfx, "_vs"},    int'(o_vs), 1);
        check_eq({pfx, "_blank"}, int'(o_blank_n), 0);
        check_eq({pfx, "_tick"},  int'(o_tick), 0);
        check_eq({pfx, "_syncn"}, int'(o_sync_n), 0);
    endtask

    task automatic model_restart();
        mh = 0; mv = 0; cyc = 0;
        red_pipe = '0; i_red = '0;
        prev_hs = 1'b1; prev_vs = 1'b1;
        hs_fall = -1; vs_fall = -1; tick_last = -1;
        sb.delete();
        sb.push_back(EXP_IDLE);
        sb.push_back(EXP_IDLE);
    endtask

    task automatic step();
        exp_t e, o;
        logic vis;
        @(negedge clk);
        vis = (mh < H_VIS) && (mv < V_VIS);
        check_eq("x",    int'(o_x),   vis ? mh : 0);
        check_eq("y",    int'(o_y),   vis ? mv : 0);
        check_eq("req",  int'(o_req), int'(vis));
        check_eq("tick", int'(o_tick), int'((mh == 0) && (mv == V_VIS)));

        e.r     = vis ? 10'(mh) : 10'd0;
        e.g     = vis ? 10'd1023 : 10'd0;
        e.b     = vis ? 10'd1023 : 10'd0;
        e.hs    = !((mh >= HS0) && (mh <= HS1));
        e.vs    = !((mv >= VS0) && (mv <= VS1));
        e.blank = vis;
        sb.push_back(e);
        o = sb.pop_front();
        check_eq("r",     int'(o_r),       int'(o.r));
        check_eq("g",     int'(o_g),       int'(o.g));
        check_eq("b",     int'(o_b),       int'(o.b));
        check_eq("hs",    int'(o_hs),      int'(o.hs));
        check_eq("vs",    int'(o_vs),      int'(o.vs));
        check_eq("blank", int'(o_blank_n), int'(o.blank));

        if (prev_hs && !o_hs) begin
            if (hs_fall < 0) check_eq("hs_first_fall", cyc, HS0 + 2);
            else             check_eq("hs_period", cyc - hs_fall, H_TOT);
            hs_fall = cyc;
        end
        if (!prev_hs && o_hs && hs_fall >= 0) check_eq("hs_low_len", cyc - hs_fall, HS1 - HS0 + 1);
        if (prev_vs && !o_vs) begin
            if (vs_fall < 0) check_eq("vs_first_fall", cyc, VS0 * H_TOT + 2);
            else             check_eq("vs_period", cyc - vs_fall, FRAME);
            vs_fall = cyc;
        end
        if (!prev_vs && o_vs && vs_fall >= 0) check_eq("vs_low_len", cyc - vs_fall, V_SYNC * H_TOT);
        if (o_tick) begin
            if (tick_last < 0) check_eq("tick_first", cyc, V_VIS * H_TOT);
            else               check_eq("tick_period", cyc - tick_last, FRAME);
            tick_last = cyc;
        end
        prev_hs = o_hs;
        prev_vs = o_vs;

        // One-cycle registered pattern generator: red echoes the X seen a cycle earlier.
        i_red    = red_pipe;
        red_pipe = o_x;

        mh++;
        if (mh == H_TOT) begin
            mh = 0;
            mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end
        cyc++;
    endtask

    initial begin
        model_restart();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_reset_vals("rst");
        end
        model_restart();
        rst_n = 1'b1;

        for (int i = 0; i < 2 * FRAME + 5 * H_TOT + 700; i++) step();

        // Mid-frame reset landing inside an HS pulse; outputs must drop at once.
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals("arst_hold");
        end
        model_restart();
        rst_n = 1'b1;

        for (int i = 0; i < FRAME + 1000; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
